// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier datapath.
package mult_pkg;

    // Default operand width of the multiplier datapath.
    localparam int MULT_WIDTH = 4;

    // Reference {carry, sum} of two unsigned operands truncated to 'width' bits.
    // The result occupies the low width+1 bits. Callers must keep width <= 32.
    function automatic logic [32:0] ref_sum(input logic [31:0] a,
                                            input logic [31:0] m,
                                            input int unsigned width);
        logic [32:0] mask;
        logic [32:0] full;
        mask = (33'd1 << width) - 33'd1;
        full = ({1'b0, a} & mask) + ({1'b0, m} & mask);
        return full & ((mask << 1) | 33'd1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult_adder.sv
// Accumulate stage of the shift-add multiplier.
// Computes {C, Sum} = A + M through a ripple-carry chain and registers the
// result. The carry-out becomes the extra MSB of the accumulator/shift register.
module mult_adder
    import mult_pkg::*;
#(
    parameter int n = MULT_WIDTH
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic [n-1:0] A,
    input  logic [n-1:0] M,
    output logic [n-1:0] Sum,
    output logic         C
);

    logic [n:0]   carry;
    logic [n-1:0] sum_comb;

    // The chain has no carry-in.
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < n; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (M[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // Output register. A low n_reset discards the operands sampled on that edge.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            Sum <= '0;
            C   <= 1'b0;
        end else begin
            Sum <= sum_comb;
            C   <= carry[n];
        end
    end

endmodule

// File: tb/tb_mult_adder.sv
// Self-checking bench for mult_adder. It exercises an n=4 and an n=8 instance.
module tb_mult_adder;
    import mult_pkg::*;

    logic       clock;
    logic       n_reset;
    logic [3:0] a4, m4, sum4;
    logic       c4;
    logic [7:0] a8, m8, sum8;
    logic       c8;

    int vectors;
    int miscompares;

    mult_adder #(.n(4)) dut4 (
        .clock   (clock),
        .n_reset (n_reset),
        .A       (a4),
        .M       (m4),
        .Sum     (sum4),
        .C       (c4)
    );

    mult_adder #(.n(8)) dut8 (
        .clock   (clock),
        .n_reset (n_reset),
        .A       (a8),
        .M       (m8),
        .Sum     (sum8),
        .C       (c8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst_n;
        logic [3:0] a;
        logic [3:0] m;
        logic [3:0] exp_sum;
        logic       exp_c;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {C,Sum}=%0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive operands on the falling edge, then sample #1 after the rising edge.
    task automatic cycle4(input logic rst_n, input logic [3:0] a,
                          input logic [3:0] m);
        @(negedge clock);
        n_reset = rst_n;
        a4 = a;
        m4 = m;
        @(posedge clock);
        #1;
    endtask

    task automatic cycle8(input logic [7:0] a, input logic [7:0] m);
        @(negedge clock);
        n_reset = 1'b1;
        a8 = a;
        m8 = m;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [32:0] r;
        logic [7:0]  ra, rm;
        logic [4:0]  e4;
        vectors     = 0;
        miscompares = 0;
        n_reset     = 1'b0;
        a4 = 4'd5; m4 = 4'd7;
        a8 = 8'd0; m8 = 8'd0;

        // rst_n, A, M, expected Sum, expected C (hand-computed)
        tbl[0]  = '{1'b0, 4'd5,  4'd7,  4'd0,  1'b0};
        tbl[1]  = '{1'b0, 4'd5,  4'd7,  4'd0,  1'b0};
        tbl[2]  = '{1'b1, 4'd5,  4'd7,  4'd12, 1'b0};
        tbl[3]  = '{1'b1, 4'd1,  4'd15, 4'd0,  1'b1};
        tbl[4]  = '{1'b1, 4'd2,  4'd15, 4'd1,  1'b1};
        tbl[5]  = '{1'b1, 4'd3,  4'd15, 4'd2,  1'b1};
        tbl[6]  = '{1'b1, 4'd15, 4'd15, 4'd14, 1'b1};
        tbl[7]  = '{1'b1, 4'd8,  4'd8,  4'd0,  1'b1};
        tbl[8]  = '{1'b1, 4'd7,  4'd8,  4'd15, 1'b0};
        tbl[9]  = '{1'b1, 4'd0,  4'd0,  4'd0,  1'b0};
        tbl[10] = '{1'b1, 4'd10, 4'd5,  4'd15, 1'b0};
        tbl[11] = '{1'b1, 4'd6,  4'd9,  4'd15, 1'b0};
        tbl[12] = '{1'b1, 4'd12, 4'd6,  4'd2,  1'b1};
        tbl[13] = '{1'b0, 4'd9,  4'd9,  4'd0,  1'b0};
        tbl[14] = '{1'b1, 4'd4,  4'd3,  4'd7,  1'b0};
        tbl[15] = '{1'b1, 4'd9,  4'd9,  4'd2,  1'b1};

        for (int i = 0; i < 16; i++) begin
            cycle4(tbl[i].rst_n, tbl[i].a, tbl[i].m);
            check($sformatf("table[%0d]", i), {4'd0, c4, sum4},
                  {4'd0, tbl[i].exp_c, tbl[i].exp_sum});
        end

        // Outputs must hold while operands change between edges.
        a4 = 4'd15; m4 = 4'd15;
        #2;
        check("hold_between_edges", {4'd0, c4, sum4}, {4'd0, 1'b1, 4'd2});

        // Sweep: A=0, M=0..15, Sum follows M one cycle later.
        for (int i = 0; i < 16; i++) begin
            cycle4(1'b1, 4'd0, 4'(i));
            check($sformatf("sweep_m%0d", i), {4'd0, c4, sum4}, {5'd0, 4'(i)});
        end

        // Reset pulse mid-stream with operands that would carry.
        cycle4(1'b1, 4'd11, 4'd11);
        check("pre_reset", {4'd0, c4, sum4}, {4'd0, 1'b1, 4'd6});
        cycle4(1'b0, 4'd9, 4'd9);
        check("midstream_reset", {4'd0, c4, sum4}, 9'd0);
        cycle4(1'b1, 4'd14, 4'd1);
        check("after_reset", {4'd0, c4, sum4}, {4'd0, 1'b0, 4'd15});

        // Exhaustive n=4.
        for (int a = 0; a < 16; a++) begin
            for (int m = 0; m < 16; m++) begin
                cycle4(1'b1, 4'(a), 4'(m));
                e4 = 5'(a + m);
                check($sformatf("exh_%0d_%0d", a, m), {4'd0, c4, sum4},
                      {4'd0, e4});
            end
        end

        // n=8 spot checks.
        cycle8(8'd255, 8'd1);
        check("n8_255_1", {c8, sum8}, {1'b1, 8'd0});
        cycle8(8'd255, 8'd255);
        check("n8_255_255", {c8, sum8}, {1'b1, 8'd254});
        cycle8(8'd100, 8'd27);
        check("n8_100_27", {c8, sum8}, {1'b0, 8'd127});

        // n=8 random.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rm = 8'($urandom_range(0, 255));
            cycle8(ra, rm);
            r = ref_sum({24'd0, ra}, {24'd0, rm}, 8);
            check($sformatf("n8_rand_%0d", i), {c8, sum8}, r[8:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
